// File: rtl/dg0045_ram_port_ctrl.sv
// Port controller for the DG0045 64x4 puzzle RAM.
// The RAM stores din into mem[addr] on every clock edge, so this block drives
// addr/din every cycle and writes the addressed cell back to itself unless a
// real write is intended. It serves host requests and, in idle cycles, streams
// cell contents to the display through a background scan.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | host requests accepted; free cycles feed the scan divider
// S_CLEAR | sweeping every cell to 0, one per cycle; host held off
module dg0045_ram_port_ctrl #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 4,
  parameter int SCAN_DIV = 1
) (
  input  logic              RAM_clk,
  input  logic              RAM_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              scan_en,
  output logic              scan_valid,
  output logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_data,
  output logic              frame_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [1:0]        OP_RD    = 2'b00;
  localparam logic [1:0]        OP_WR    = 2'b01;
  localparam logic [1:0]        OP_XOR   = 2'b10;
  localparam logic [1:0]        OP_CLR   = 2'b11;
  localparam logic [ADDR_W-1:0] LAST     = '1;
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
  localparam logic [7:0]        DIV_LAST = 8'(SCAN_DIV - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic [ADDR_W-1:0] r_scan_ptr;
  logic [7:0]        r_div;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_scan_valid;
  logic [ADDR_W-1:0] r_scan_addr;
  logic [DATA_W-1:0] r_scan_data;
  logic              r_frame_done;

  logic              w_ready;
  logic              w_accept;
  logic              w_free;
  logic              w_scan_step;
  logic              w_clr_last;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_din;

  assign w_ready     = (r_state == S_IDLE) && !RAM_rst;
  assign w_accept    = req_valid && w_ready;
  assign w_free      = (r_state == S_IDLE) && !w_accept && scan_en && !RAM_rst;
  assign w_scan_step = w_free && (r_div == DIV_LAST);
  assign w_clr_last  = (r_state == S_CLEAR) && (r_clr_ptr == LAST);

  // Next-state decision: clear-all enters the sweep, last cell leaves it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && (req_op == OP_CLR)) w_state_nxt = S_CLEAR;
      S_CLEAR: if (r_clr_ptr == LAST) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Port mux: reset, sweep, host, scan, hold; anything but a write refreshes the cell.
  always_comb begin
    w_ram_addr = r_ram_addr;
    w_ram_din  = ram_dout;
    if (RAM_rst) begin
      w_ram_addr = '0;
    end else if (r_state == S_CLEAR) begin
      w_ram_addr = r_clr_ptr;
      w_ram_din  = '0;
    end else if (w_accept) begin
      w_ram_addr = req_addr;
      case (req_op)
        OP_WR:   w_ram_din = req_wdata;
        OP_XOR:  w_ram_din = ram_dout ^ req_wdata;
        OP_RD:   w_ram_din = ram_dout;
        default: w_ram_din = ram_dout;
      endcase
    end else if (w_scan_step) begin
      w_ram_addr = r_scan_ptr;
    end
  end

  // State register.
  always_ff @(posedge RAM_clk) begin
    if (RAM_rst) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Sweep pointer and the remembered port address used for hold cycles.
  always_ff @(posedge RAM_clk) begin
    r_ram_addr <= w_ram_addr;
    if (RAM_rst)                  r_clr_ptr <= '0;
    else if (r_state == S_CLEAR)  r_clr_ptr <= r_clr_ptr + ONE;
  end

  // Host response: pre-op value one cycle after accept, or 0 after the sweep ends.
  always_ff @(posedge RAM_clk) begin
    if (RAM_rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_accept && (req_op != OP_CLR)) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= ram_dout;
      end else if (w_clr_last) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= '0;
      end
    end
  end

  // Background scan: divider over free cycles, pointer advances once per step.
  always_ff @(posedge RAM_clk) begin
    if (RAM_rst) begin
      r_scan_ptr   <= '0;
      r_div        <= '0;
      r_scan_valid <= 1'b0;
      r_scan_addr  <= '0;
      r_scan_data  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_scan_valid <= w_scan_step;
      r_frame_done <= w_scan_step && (r_scan_ptr == LAST);
      if (w_free) r_div <= w_scan_step ? 8'd0 : r_div + 8'd1;
      if (w_scan_step) begin
        r_scan_addr <= r_scan_ptr;
        r_scan_data <= ram_dout;
        r_scan_ptr  <= r_scan_ptr + ONE;
      end
    end
  end

  assign req_ready  = w_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign scan_valid = r_scan_valid;
  assign scan_addr  = r_scan_addr;
  assign scan_data  = r_scan_data;
  assign frame_done = r_frame_done;
  assign ram_addr   = w_ram_addr;
  assign ram_din    = w_ram_din;

endmodule
